jump_resolve_ctrl: RTL

- Issue-side controller for the jump/branch functional unit in the dynamically scheduled core; it is the initiator that drives the unit.
- Accepts one control-transfer op at a time from the issue stage and pulses the unit's enable.
- Waits the unit latency, then samples target / link / compare results.
- Produces a misprediction redirect for the fetch stage and a link-register writeback for the CDB.

---
 rtl/jump_resolve_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/jump_resolve_ctrl.sv
// Issue-side controller for the jump/branch unit: issues one op, waits FU_LATENCY
// cycles, then emits a mispredict redirect and link writeback. JUMP_STATS_EN adds counters.
module jump_resolve_ctrl #(
  parameter int unsigned FU_LATENCY = 1,
  parameter int unsigned RD_W       = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic            issue_jal,
  input  logic            issue_jalr,
  input  logic [RD_W-1:0] issue_rd,
  input  logic            issue_pred_taken,
  input  logic [31:0]     issue_pred_pc,
  input  logic            kill,
  output logic            fu_en,
  output logic            fu_jalr,
  input  logic [31:0]     fu_pc_jump,
  input  logic [31:0]     fu_pc_wb,
  input  logic            fu_cmp_res,
  output logic            redirect_valid,
  output logic [31:0]     redirect_pc,
  output logic            wb_valid,
  output logic [RD_W-1:0] wb_rd,
  output logic [31:0]     wb_data,
  output logic            busy
`ifdef JUMP_STATS_EN
  ,
  output logic [31:0]     stat_ctrl_cnt,
  output logic [31:0]     stat_mispred_cnt
`endif
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
  typedef enum logic [1:0] {KIND_BR = 2'd0, KIND_JAL = 2'd1, KIND_JALR = 2'd2} kind_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  kind_t            kind_q, issue_kind;
  logic [RD_W-1:0]  rd_q;
  logic             pred_taken_q;
  logic [31:0]      pred_pc_q;
  logic             accept;
  logic             resolve;
  logic             taken;
  logic             mispredict;
  logic [31:0]      next_pc;

  // Op kind decode: jalr wins over jal, neither bit means conditional branch
  always_comb begin
    issue_kind = KIND_BR;
    if (issue_jalr)     issue_kind = KIND_JALR;
    else if (issue_jal) issue_kind = KIND_JAL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, handshake and unit enable
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    resolve     = 1'b0;
    issue_ready = (state_q == IDLE) && !kill;
    accept      = issue_valid && issue_ready;
    fu_en       = accept;
    fu_jalr     = accept && issue_jalr;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(FU_LATENCY);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (kill) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          resolve = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == WAIT);

  // Resolution against the fetch-stage prediction
  always_comb begin
    taken      = (kind_q != KIND_BR) ? 1'b1 : fu_cmp_res;
    next_pc    = taken ? fu_pc_jump : fu_pc_wb;
    mispredict = (taken != pred_taken_q) || (taken && (next_pc != pred_pc_q));
  end

  // Op latch and registered result pulses; data outputs hold between pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kind_q         <= KIND_BR;
      rd_q           <= '0;
      pred_taken_q   <= 1'b0;
      pred_pc_q      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
    end else begin
      redirect_valid <= 1'b0;
      wb_valid       <= 1'b0;
      if (accept) begin
        kind_q       <= issue_kind;
        rd_q         <= issue_rd;
        pred_taken_q <= issue_pred_taken;
        pred_pc_q    <= issue_pred_pc;
      end
      if (resolve) begin
        redirect_valid <= mispredict;
        redirect_pc    <= next_pc;
        wb_valid       <= (kind_q != KIND_BR) && (rd_q != '0);
        wb_rd          <= rd_q;
        wb_data        <= fu_pc_wb;
      end
    end
  end

`ifdef JUMP_STATS_EN
  // Resolution and mispredict counters, wrapping, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ctrl_cnt    <= '0;
      stat_mispred_cnt <= '0;
    end else if (resolve) begin
      stat_ctrl_cnt <= stat_ctrl_cnt + 32'd1;
      if (mispredict) stat_mispred_cnt <= stat_mispred_cnt + 32'd1;
    end
  end
`endif

endmodule
